// File: rtl/demux_stream.sv
// One-to-CH stream demultiplexer with a one-entry register per output channel.
// Optional broadcast to every channel is enabled by defining DEMUX_STREAM_BCAST_EN.
module demux_stream #(
  parameter int W  = 8,
  parameter int CH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          in_data,
  input  logic [$clog2(CH)-1:0] in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CH*W-1:0]       out_data,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int SEL_W = $clog2(CH);
  localparam logic [SEL_W:0] CH_EXT = (SEL_W+1)'(CH);

  logic [CH-1:0]   valid_q;
  logic [CH*W-1:0] data_q;
  logic            err_q;

  logic [CH-1:0]   chan_free;
  logic [CH-1:0]   load;
  logic            bcast_mode;
  logic            in_range;
  logic            sel_free;
  logic            err_set;
  logic            ready_int;

`ifdef DEMUX_STREAM_BCAST_EN
  assign bcast_mode = in_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast_mode   = 1'b0;
`endif

  // A channel may take new data if it is empty or being drained on this same edge.
  always_comb begin
    chan_free = ~valid_q | out_ready;
    in_range  = ({1'b0, in_sel} < CH_EXT);
    sel_free  = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_free = chan_free[k];
    end
  end

  always_comb begin
    ready_int = 1'b0;
    load      = '0;
    err_set   = 1'b0;
    if (bcast_mode) begin
      ready_int = &chan_free;
      load      = {CH{in_valid & ready_int}};
    end else if (in_range) begin
      ready_int = sel_free;
      for (int k = 0; k < CH; k++) begin
        if (in_sel == SEL_W'(k)) load[k] = in_valid & sel_free;
      end
    end else begin
      // Out-of-range selects are swallowed so the upstream never deadlocks.
      ready_int = 1'b1;
      err_set   = in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (load[k]) begin
          valid_q[k]        <= 1'b1;
          data_q[k*W +: W]  <= in_data;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign in_ready  = ready_int;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err       = err_q;

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter W, default 8, data width in bits (1..64).
REQ-002 Parameter CH, default 16, output channel count (2..16).
REQ-003 Localparam SEL_W SHALL be $clog2(CH) and set the IN_SEL width.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 IN_DATA  input  W  input payload.
REQ-007 IN_SEL  input  SEL_W  destination channel index.
REQ-008 IN_BCAST  input  1  when high, the transfer goes to all channels and IN_SEL is ignored.
REQ-009 IN_VALID  input  1  input payload valid.
REQ-010 IN_READY  output  1  block can accept the input this cycle.
REQ-011 OUT_DATA  output  CH*W  per-channel payload; channel k occupies bits [k*W +: W].
REQ-012 OUT_VALID  output  CH  per-channel valid.
REQ-013 OUT_READY  input  CH  per-channel sink ready.
REQ-014 ERR  output  1  sticky flag: an out-of-range IN_SEL was accepted.
REQ-015 ERR_CLR  input  1  synchronous clear of ERR.

Function
REQ-016 Each channel SHALL hold a one-entry register (data plus valid); OUT_DATA[k] and OUT_VALID[k] SHALL come directly from that register.
REQ-017 A channel is "free" in a cycle when its valid bit is 0 or OUT_READY[k] is 1 in that same cycle.
REQ-018 A transfer occurs when IN_VALID and IN_READY are both 1.
REQ-019 In unicast mode (IN_BCAST=0) with IN_SEL<CH, IN_READY SHALL equal the free status of channel IN_SEL.
REQ-020 In unicast mode with IN_SEL>=CH, IN_READY SHALL be 1, the payload SHALL be discarded, and ERR SHALL set on the next edge.
REQ-021 In broadcast mode (IN_BCAST=1), IN_READY SHALL be 1 only when every channel is free; the transfer loads every channel with IN_DATA.
REQ-022 Latency: data transferred at edge t SHALL appear on OUT_DATA/OUT_VALID of the target channel(s) after edge t, i.e. one cycle.
REQ-023 Output handshake: OUT_VALID[k]&OUT_READY[k] at an edge SHALL clear valid[k] unless the same edge reloads channel k.
REQ-024 Simultaneous drain and reload of one channel SHALL keep valid[k]=1 with the new data, giving full throughput of one transfer per cycle per channel.
REQ-025 OUT_DATA[k] SHALL remain stable while OUT_VALID[k]=1 and OUT_READY[k]=0.
REQ-026 Channels not targeted by a transfer SHALL keep their state, except for their own drain.
REQ-027 ERR_CLR and a new error in the same cycle SHALL leave ERR=1 (set wins).
REQ-028 IN_READY SHALL be combinational from IN_SEL, IN_BCAST, OUT_READY and the channel state, and SHALL NOT depend on IN_VALID.

Reset
REQ-029 When RST_N=0, asynchronously: all valid bits=0, OUT_VALID=0, all OUT_DATA=0, ERR=0.
REQ-030 Any transfer in flight when reset asserts SHALL be lost; no output SHALL assert valid until the first transfer after RST_N deasserts.
REQ-031 IN_READY SHALL be 1 during reset for in-range selects, but no state SHALL change while RST_N=0.

Configuration
REQ-032 Macro DEMUX_STREAM_BCAST_EN: when defined, broadcast operates per REQ-021.
REQ-033 When DEMUX_STREAM_BCAST_EN is undefined, IN_BCAST SHALL be ignored (treated as 0) and the port SHALL remain present.

Verification
REQ-034 Reset then IN_SEL=5, IN_DATA=8'hA5, one-cycle valid, OUT_READY=0 -> OUT_VALID=16'h0020 next cycle, OUT_DATA[5]=A5, held stable.
REQ-035 Channel 5 full with OUT_READY[5]=0, new input to channel 5 -> IN_READY=0; raise OUT_READY[5] -> IN_READY=1, and the drain plus reload on the same edge leaves channel 5 valid with the new data.
REQ-036 Back-to-back inputs to channel 3 at 1/cycle with OUT_READY[3]=1 -> 10 words in produce 10 words out in order, with no bubbles.
REQ-037 CH=10 and IN_SEL=12 -> IN_READY=1, no OUT_VALID change, ERR=1; ERR_CLR pulse -> ERR=0.
REQ-038 With BCAST_EN defined, channel 7 full and stalled, IN_BCAST=1 with 8'h3C -> IN_READY=0; release channel 7 -> all OUT_VALID=1, all data 3C. With the macro undefined, the same stimulus loads only channel IN_SEL.
REQ-039 Assert RST_N=0 mid-stream with several channels valid -> all outputs and ERR go to 0 immediately, without waiting for a clock edge.
